// File: rtl/mram_march_bist_if.sv
// rtl/mram_march_bist_if.sv - MRAM bank bus between the March BIST engine and the bank
//
// Purpose : bundles the bank-side signals of one MRAM word bank.
// Signals : A     - address low bits (2)
//           X     - address high bits (8)
//           CEB   - chip enable, active low
//           WEB   - write enable, 0 = write, 1 = read
//           BEN   - byte-lane enables, 1 = lane enabled
//           Din   - write data (TOTAL_WIDTH)
//           MEM_Q - read data from the bank (TOTAL_WIDTH)
// Modports: master = BIST engine side, slave = bank side.
interface mram_march_bist_if #(
  parameter int TOTAL_WIDTH = 52
);
  logic [1:0]             A;
  logic [7:0]             X;
  logic                   CEB;
  logic                   WEB;
  logic [3:0]             BEN;
  logic [TOTAL_WIDTH-1:0] Din;
  logic [TOTAL_WIDTH-1:0] MEM_Q;

  modport master (
    output A, X, CEB, WEB, BEN, Din,
    input  MEM_Q
  );

  modport slave (
    input  A, X, CEB, WEB, BEN, Din,
    output MEM_Q
  );
endinterface

// File: rtl/mram_march_bist.sv
// rtl/mram_march_bist.sv - March C- built-in self test engine for one MRAM word bank
//
// Purpose : runs March C- (up w0; up r0,w1; up r1,w0; down r0,w1; down r1,w0; up r0)
//           over every word of the bank, counting mismatching reads and capturing
//           the first failure.
// Ports   : CLK       - clock, rising edge
//           RSTB      - asynchronous active-low reset
//           START     - test start request, honoured only in IDLE
//           ABORT     - terminates a running test, wins over START
//           BUSY      - high while a test runs
//           DONE      - one-cycle completion pulse
//           PASS      - test result, valid from DONE until the next accepted START
//           FAIL_CNT  - saturating count of mismatching reads
//           FAIL_ADDR - word address of the first mismatch
//           FAIL_ELEM - March element (0..5) of the first mismatch
//           FAIL_SYN  - MEM_Q XOR expected word at the first mismatch
//           bank      - bank bus (A, X, CEB, WEB, BEN, Din, MEM_Q), master side
module mram_march_bist #(
  parameter int ADDR_WIDTH  = 10,
  parameter int TOTAL_WIDTH = 52,
  parameter int ACC_CYC     = 4
) (
  input  logic                   CLK,
  input  logic                   RSTB,
  input  logic                   START,
  input  logic                   ABORT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   PASS,
  output logic [7:0]             FAIL_CNT,
  output logic [ADDR_WIDTH-1:0]  FAIL_ADDR,
  output logic [2:0]             FAIL_ELEM,
  output logic [TOTAL_WIDTH-1:0] FAIL_SYN,
  mram_march_bist_if.master      bank
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [3:0]            LAST_CYC = 4'(ACC_CYC - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  logic [2:0]             r_elem;
  logic                   r_sub;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [3:0]             r_cyc;
  logic                   r_ceb;
  logic                   r_web;
  logic [3:0]             r_ben;
  logic [TOTAL_WIDTH-1:0] r_din;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [7:0]             r_fail_cnt;
  logic [ADDR_WIDTH-1:0]  r_fail_addr;
  logic [2:0]             r_fail_elem;
  logic [TOTAL_WIDTH-1:0] r_fail_syn;

  // Operation code of (element, sub-operation): [1] = write, [0] = data bit.
  // Elements 0 and 5 have a single op; the others are read-then-write.
  function automatic logic [1:0] op_code(input logic [2:0] elem, input logic sub);
    case (elem)
      3'd0:       op_code = 2'b10;
      3'd1, 3'd3: op_code = {sub, sub};
      3'd2, 3'd4: op_code = {sub, ~sub};
      default:    op_code = 2'b00;
    endcase
  endfunction

  logic [1:0]             w_cur_op;
  logic [1:0]             w_nxt_op;
  logic                   w_is_down;
  logic                   w_last_sub;
  logic                   w_last_addr;
  logic [2:0]             w_nxt_elem;
  logic                   w_nxt_sub;
  logic [ADDR_WIDTH-1:0]  w_nxt_addr;
  logic                   w_test_end;
  logic [TOTAL_WIDTH-1:0] w_syn;
  logic                   w_mismatch;
  logic [9:0]             w_addr_ext;

  assign w_cur_op    = op_code(r_elem, r_sub);
  assign w_is_down   = (r_elem == 3'd3) || (r_elem == 3'd4);
  assign w_last_sub  = (r_elem == 3'd0) || (r_elem == 3'd5) || r_sub;
  assign w_last_addr = w_is_down ? (r_addr == '0) : (r_addr == ADDR_MAX);

  // Sequencing of the next operation, evaluated while in GAP.
  always_comb begin
    w_nxt_elem = r_elem;
    w_nxt_sub  = 1'b0;
    w_nxt_addr = r_addr;
    w_test_end = 1'b0;
    if (!w_last_sub) begin
      w_nxt_sub = 1'b1;
    end else if (!w_last_addr) begin
      w_nxt_addr = w_is_down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
    end else if (r_elem == 3'd5) begin
      w_test_end = 1'b1;
    end else begin
      // Element boundary: reload the counter for the new direction.
      w_nxt_elem = r_elem + 3'd1;
      w_nxt_addr = ((w_nxt_elem == 3'd3) || (w_nxt_elem == 3'd4)) ? ADDR_MAX : '0;
    end
  end

  assign w_nxt_op   = op_code(w_nxt_elem, w_nxt_sub);
  assign w_syn      = bank.MEM_Q ^ {TOTAL_WIDTH{w_cur_op[0]}};
  assign w_mismatch = |w_syn;

  // Word address is presented as {X, A}; unused high X bits stay zero.
  always_comb begin
    w_addr_ext = '0;
    w_addr_ext[ADDR_WIDTH-1:0] = r_addr;
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= IDLE;
      r_elem      <= 3'd0;
      r_sub       <= 1'b0;
      r_addr      <= '0;
      r_cyc       <= 4'd0;
      r_ceb       <= 1'b1;
      r_web       <= 1'b1;
      r_ben       <= 4'b0000;
      r_din       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_cnt  <= 8'd0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_syn  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START && !ABORT) begin
            r_state     <= OP;
            r_elem      <= 3'd0;
            r_sub       <= 1'b0;
            r_addr      <= '0;
            r_cyc       <= 4'd0;
            r_ceb       <= 1'b0;
            r_web       <= 1'b0;
            r_ben       <= 4'b1111;
            r_din       <= '0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_cnt  <= 8'd0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
            r_fail_syn  <= '0;
          end
        end

        OP: begin
          if (ABORT) begin
            r_state <= IDLE;
            r_ceb   <= 1'b1;
            r_web   <= 1'b1;
            r_ben   <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_cyc == LAST_CYC) begin
            r_state <= GAP;
            r_ceb   <= 1'b1;
            r_web   <= 1'b1;
            r_ben   <= 4'b0000;
            // MEM_Q is only looked at here, on the last cycle of a read.
            if (!w_cur_op[1] && w_mismatch) begin
              if (r_fail_cnt != 8'hFF) begin
                r_fail_cnt <= r_fail_cnt + 8'd1;
              end
              if (r_fail_cnt == 8'd0) begin
                r_fail_addr <= r_addr;
                r_fail_elem <= r_elem;
                r_fail_syn  <= w_syn;
              end
            end
          end else begin
            r_cyc <= r_cyc + 4'd1;
          end
        end

        GAP: begin
          if (ABORT) begin
            r_state <= IDLE;
            r_ceb   <= 1'b1;
            r_web   <= 1'b1;
            r_ben   <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (w_test_end) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_fail_cnt == 8'd0);
          end else begin
            r_state <= OP;
            r_elem  <= w_nxt_elem;
            r_sub   <= w_nxt_sub;
            r_addr  <= w_nxt_addr;
            r_cyc   <= 4'd0;
            r_ceb   <= 1'b0;
            r_web   <= ~w_nxt_op[1];
            r_ben   <= 4'b1111;
            r_din   <= {TOTAL_WIDTH{w_nxt_op[0]}};
          end
        end

        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          if (ABORT) begin
            r_pass <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign FAIL_CNT  = r_fail_cnt;
  assign FAIL_ADDR = r_fail_addr;
  assign FAIL_ELEM = r_fail_elem;
  assign FAIL_SYN  = r_fail_syn;

  assign bank.A    = w_addr_ext[1:0];
  assign bank.X    = w_addr_ext[9:2];
  assign bank.CEB  = r_ceb;
  assign bank.WEB  = r_web;
  assign bank.BEN  = r_ben;
  assign bank.Din  = r_din;

endmodule

// File: tb/tb_mram_march_bist.sv
// tb/tb_mram_march_bist.sv - directed self-checking bench for mram_march_bist
module tb_mram_march_bist;

  localparam int AW      = 7;
  localparam int TW      = 52;
  localparam int ACC     = 4;
  localparam int NWORDS  = 1 << AW;
  localparam int RUN_CYC = 10 * NWORDS * (ACC + 1);
  localparam int M3_START = 1 + 5 * NWORDS * (ACC + 1);

  logic          CLK = 1'b0;
  logic          RSTB;
  logic          START;
  logic          ABORT;
  logic          BUSY;
  logic          DONE;
  logic          PASS;
  logic [7:0]    FAIL_CNT;
  logic [AW-1:0] FAIL_ADDR;
  logic [2:0]    FAIL_ELEM;
  logic [TW-1:0] FAIL_SYN;

  int errors = 0;
  int checks = 0;

  mram_march_bist_if #(.TOTAL_WIDTH(TW)) bank ();

  mram_march_bist #(
    .ADDR_WIDTH (AW),
    .TOTAL_WIDTH(TW),
    .ACC_CYC    (ACC)
  ) dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .START    (START),
    .ABORT    (ABORT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS     (PASS),
    .FAIL_CNT (FAIL_CNT),
    .FAIL_ADDR(FAIL_ADDR),
    .FAIL_ELEM(FAIL_ELEM),
    .FAIL_SYN (FAIL_SYN),
    .bank     (bank.master)
  );

  always #5 CLK = ~CLK;

  // Bank model with injectable stuck-at faults on one word.
  logic [TW-1:0] mem [0:1023];
  logic [9:0]    maddr;
  logic [9:0]    fault_addr;
  logic [TW-1:0] sa0_mask;
  logic [TW-1:0] sa1_mask;
  logic          tie_ones;

  assign maddr = {bank.X, bank.A};

  always @(posedge CLK) begin
    if (!bank.CEB && !bank.WEB) mem[maddr] <= bank.Din;
  end

  always_comb begin
    bank.MEM_Q = 'x;
    if (!bank.CEB && bank.WEB) begin
      if (tie_ones) bank.MEM_Q = '1;
      else if (maddr == fault_addr) bank.MEM_Q = (mem[maddr] & ~sa0_mask) | sa1_mask;
      else bank.MEM_Q = mem[maddr];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_faults();
    fault_addr = 10'h3FF;
    sa0_mask   = '0;
    sa1_mask   = '0;
    tie_ones   = 1'b0;
  endtask

  // Accept START, then run until DONE; n is the 1-based cycle index where the
  // first OP cycle is n=1. Optionally pulses START at cycle pulse_at.
  task automatic start_test(output int n);
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 1;
  endtask

  task automatic wait_done(input int pulse_at, inout int n);
    while (DONE !== 1'b1 && n < RUN_CYC + 200) begin
      START = (n == pulse_at);
      tick();
      n++;
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RSTB = 1'b0; START = 1'b0; ABORT = 1'b0;
    tick(); tick();
    checks++;
    if ({bank.CEB, bank.WEB, bank.BEN, bank.A, bank.X} !== {1'b1, 1'b1, 4'h0, 2'd0, 8'd0}) begin
      errors++; $display("FAIL reset_bank: got ceb=%b web=%b ben=%h a=%0d x=%0d expected 1 1 0 0 0",
                         bank.CEB, bank.WEB, bank.BEN, bank.A, bank.X);
    end
    checks++;
    if ({BUSY, DONE, PASS, FAIL_CNT, FAIL_ELEM} !== 13'd0 || FAIL_ADDR !== '0 || FAIL_SYN !== '0 || bank.Din !== '0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b pass=%b cnt=%0d addr=%0d elem=%0d syn=%h din=%h expected all 0",
                         BUSY, DONE, PASS, FAIL_CNT, FAIL_ADDR, FAIL_ELEM, FAIL_SYN, bank.Din);
    end
    RSTB = 1'b1;
    tick();
  endtask

  task automatic test_fault_free();
    int n;
    clear_faults();
    start_test(n);
    checks++;
    if ({BUSY, bank.CEB, bank.WEB, bank.BEN} !== {1'b1, 1'b0, 1'b0, 4'hF} || maddr !== 10'd0 || bank.Din !== '0) begin
      errors++; $display("FAIL first_op: got busy=%b ceb=%b web=%b ben=%h addr=%0d expected 1 0 0 f 0",
                         BUSY, bank.CEB, bank.WEB, bank.BEN, maddr);
    end
    tick(); tick(); tick(); n += 3;
    checks++;
    if (bank.CEB !== 1'b0 || maddr !== 10'd0) begin
      errors++; $display("FAIL op_hold: got ceb=%b addr=%0d expected 0 0", bank.CEB, maddr);
    end
    tick(); n++;
    checks++;
    if (bank.CEB !== 1'b1 || bank.WEB !== 1'b1) begin
      errors++; $display("FAIL gap: got ceb=%b web=%b expected 1 1", bank.CEB, bank.WEB);
    end
    tick(); n++;
    checks++;
    if (bank.CEB !== 1'b0 || maddr !== 10'd1 || bank.WEB !== 1'b0) begin
      errors++; $display("FAIL second_op: got ceb=%b addr=%0d web=%b expected 0 1 0", bank.CEB, maddr, bank.WEB);
    end
    wait_done(-1, n);
    checks++;
    if (DONE !== 1'b1 || n != RUN_CYC + 1) begin
      errors++; $display("FAIL clean_latency: got done=%b at cycle %0d expected 1 at %0d", DONE, n, RUN_CYC + 1);
    end
    checks++;
    if ({BUSY, PASS, FAIL_CNT} !== {1'b0, 1'b1, 8'd0}) begin
      errors++; $display("FAIL clean_result: got busy=%b pass=%b cnt=%0d expected 0 1 0", BUSY, PASS, FAIL_CNT);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || PASS !== 1'b1) begin
      errors++; $display("FAIL done_pulse: got done=%b pass=%b expected 0 1", DONE, PASS);
    end
  endtask

  task automatic test_stuck_at0();
    int n;
    clear_faults();
    fault_addr = 10'd0;
    sa0_mask   = 52'h1;
    start_test(n);
    checks++;
    if (PASS !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL pass_cleared: got pass=%b busy=%b expected 0 1", PASS, BUSY);
    end
    wait_done(-1, n);
    checks++;
    if (DONE !== 1'b1 || FAIL_CNT !== 8'd2 || FAIL_ADDR !== 7'd0 || FAIL_ELEM !== 3'd2 || FAIL_SYN !== 52'h1 || PASS !== 1'b0) begin
      errors++; $display("FAIL sa0: got done=%b cnt=%0d addr=%0d elem=%0d syn=%h pass=%b expected 1 2 0 2 1 0",
                         DONE, FAIL_CNT, FAIL_ADDR, FAIL_ELEM, FAIL_SYN, PASS);
    end
    tick();
  endtask

  task automatic test_stuck_at1();
    int n;
    clear_faults();
    fault_addr = 10'd1;
    sa1_mask   = 52'h800;
    start_test(n);
    checks++;
    if (FAIL_CNT !== 8'd0 || FAIL_SYN !== '0 || FAIL_ELEM !== 3'd0) begin
      errors++; $display("FAIL fail_cleared: got cnt=%0d syn=%h elem=%0d expected 0 0 0", FAIL_CNT, FAIL_SYN, FAIL_ELEM);
    end
    wait_done(-1, n);
    checks++;
    if (DONE !== 1'b1 || FAIL_CNT !== 8'd3 || FAIL_ADDR !== 7'd1 || FAIL_ELEM !== 3'd1 || FAIL_SYN !== 52'h800 || PASS !== 1'b0) begin
      errors++; $display("FAIL sa1: got done=%b cnt=%0d addr=%0d elem=%0d syn=%h pass=%b expected 1 3 1 1 800 0",
                         DONE, FAIL_CNT, FAIL_ADDR, FAIL_ELEM, FAIL_SYN, PASS);
    end
    tick();
  endtask

  task automatic test_saturate();
    int n;
    clear_faults();
    tie_ones = 1'b1;
    start_test(n);
    wait_done(-1, n);
    checks++;
    if (DONE !== 1'b1 || FAIL_CNT !== 8'd255 || FAIL_ADDR !== 7'd0 || FAIL_ELEM !== 3'd1 || PASS !== 1'b0 || FAIL_SYN !== '1) begin
      errors++; $display("FAIL saturate: got done=%b cnt=%0d addr=%0d elem=%0d pass=%b syn=%h expected 1 255 0 1 0 all-ones",
                         DONE, FAIL_CNT, FAIL_ADDR, FAIL_ELEM, PASS, FAIL_SYN);
    end
    tick();
    clear_faults();
  endtask

  task automatic test_start_while_busy();
    int n;
    clear_faults();
    start_test(n);
    wait_done(1000, n);
    checks++;
    if (DONE !== 1'b1 || n != RUN_CYC + 1 || PASS !== 1'b1 || FAIL_CNT !== 8'd0) begin
      errors++; $display("FAIL start_ignored: got done=%b cycle=%0d pass=%b cnt=%0d expected 1 %0d 1 0",
                         DONE, n, PASS, FAIL_CNT, RUN_CYC + 1);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || bank.CEB !== 1'b1) begin
      errors++; $display("FAIL idle_after_run: got busy=%b ceb=%b expected 0 1", BUSY, bank.CEB);
    end
  endtask

  task automatic test_abort_priority();
    START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || bank.CEB !== 1'b1) begin
      errors++; $display("FAIL abort_priority: got busy=%b ceb=%b expected 0 1", BUSY, bank.CEB);
    end
  endtask

  task automatic test_abort_m3();
    int n;
    bit saw_done;
    clear_faults();
    fault_addr = 10'd1;
    sa1_mask   = 52'h800;
    start_test(n);
    while (n < M3_START) begin tick(); n++; end
    checks++;
    if (bank.CEB !== 1'b0 || bank.WEB !== 1'b1 || maddr !== 10'(NWORDS - 1)) begin
      errors++; $display("FAIL m3_first: got ceb=%b web=%b addr=%0d expected 0 1 %0d", bank.CEB, bank.WEB, maddr, NWORDS - 1);
    end
    for (int i = 0; i < 10; i++) begin tick(); n++; end
    checks++;
    if (bank.WEB !== 1'b1 || maddr !== 10'(NWORDS - 2)) begin
      errors++; $display("FAIL m3_down: got web=%b addr=%0d expected 1 %0d", bank.WEB, maddr, NWORDS - 2);
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if ({bank.CEB, BUSY, DONE, PASS} !== 4'b1000) begin
      errors++; $display("FAIL abort_state: got ceb=%b busy=%b done=%b pass=%b expected 1 0 0 0", bank.CEB, BUSY, DONE, PASS);
    end
    checks++;
    if (FAIL_CNT !== 8'd1 || FAIL_ELEM !== 3'd1 || FAIL_ADDR !== 7'd1) begin
      errors++; $display("FAIL abort_keep: got cnt=%0d elem=%0d addr=%0d expected 1 1 1", FAIL_CNT, FAIL_ELEM, FAIL_ADDR);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DONE === 1'b1 || bank.CEB !== 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got activity=%b expected 0", saw_done);
    end
    clear_faults();
    start_test(n);
    wait_done(-1, n);
    checks++;
    if (DONE !== 1'b1 || n != RUN_CYC + 1 || PASS !== 1'b1) begin
      errors++; $display("FAIL rerun: got done=%b cycle=%0d pass=%b expected 1 %0d 1", DONE, n, PASS, RUN_CYC + 1);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int n;
    clear_faults();
    fault_addr = 10'd1;
    sa1_mask   = 52'h800;
    start_test(n);
    while (n < 703) begin tick(); n++; end
    checks++;
    if (bank.CEB !== 1'b0 || FAIL_CNT !== 8'd1) begin
      errors++; $display("FAIL pre_reset: got ceb=%b cnt=%0d expected 0 1", bank.CEB, FAIL_CNT);
    end
    #2;
    RSTB = 1'b0;
    #1;
    checks++;
    if ({bank.CEB, bank.WEB, bank.BEN, bank.A, bank.X, BUSY, DONE, PASS} !== {1'b1, 1'b1, 4'h0, 2'd0, 8'd0, 3'b000} ||
        bank.Din !== '0 || FAIL_CNT !== 8'd0 || FAIL_ADDR !== '0 || FAIL_ELEM !== 3'd0 || FAIL_SYN !== '0) begin
      errors++; $display("FAIL async_reset: got ceb=%b web=%b ben=%h addr=%0d busy=%b done=%b pass=%b cnt=%0d expected reset values",
                         bank.CEB, bank.WEB, bank.BEN, maddr, BUSY, DONE, PASS, FAIL_CNT);
    end
    tick(); tick();
    RSTB = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (BUSY !== 1'b0 || bank.CEB !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b ceb=%b expected 0 1", BUSY, bank.CEB);
    end
    clear_faults();
  endtask

  initial begin
    clear_faults();
    RSTB = 1'b0; START = 1'b0; ABORT = 1'b0;
    test_reset();
    test_fault_free();
    test_stuck_at0();
    test_stuck_at1();
    test_saturate();
    test_start_while_busy();
    test_abort_priority();
    test_abort_m3();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
